// File: rtl/key_schedule_iter.sv
// rtl/key_schedule_iter.sv - iterative AES key-schedule engine, one word per clock
//
// aes_sbox: combinational AES S-box (GF(2^8) inverse followed by the affine map).
//   a : input byte
//   s : substituted byte
//
// key_schedule_iter: expands a 128/192/256-bit key into Nr+1 round keys,
// stores them in a word array and serves one round key per cycle.
//   iClk       : clock
//   iRst       : synchronous active-high reset
//   iStart     : start request, honoured in IDLE only
//   iKey       : cipher key, word 0 in the top 32 bits
//   iRoundIdx  : round index for the read port
//   iDecrypt   : 1 reverses the round order on the read port
//   oBusy      : expansion in progress
//   oDone      : one-cycle pulse at the end of expansion
//   oKeyValid  : whole schedule in the array is valid
//   oRoundKey  : registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    always_comb begin
        logic [7:0] sq;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module key_schedule_iter #(
    parameter int KEY_SIZE = 128
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic [3:0]          iRoundIdx,
    input  logic                iDecrypt,
    output logic                oBusy,
    output logic                oDone,
    output logic                oKeyValid,
    output logic [127:0]        oRoundKey
);

    // Unsupported key sizes fall back to the AES-128 schedule.
    localparam int NK          = (KEY_SIZE == 256) ? 8 : (KEY_SIZE == 192) ? 6 : 4;
    localparam int NR          = NK + 6;
    localparam int TOTAL_WORDS = 4 * (NR + 1);
    localparam int KW          = 32 * NK;

    localparam logic [5:0] NK_CNT   = 6'(NK);
    localparam logic [5:0] LAST_CNT = 6'(TOTAL_WORDS - 1);
    localparam logic [2:0] LAST_POS = 3'(NK - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [2:0]  pos;      // cnt mod Nk, tracked incrementally instead of dividing
    logic [7:0]  rcon;
    logic [31:0] w [0:TOTAL_WORDS-1];

    logic [KW-1:0]  key_norm;
    logic [31:0]    prev_word;
    logic [31:0]    back_word;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    new_word;
    logic [3:0]     rd_round;
    logic [5:0]     rd_base;
    logic [127:0]   rd_key;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Left-align the key into exactly Nk words.
    generate
        if (KEY_SIZE >= KW) begin : g_key_trunc
            assign key_norm = iKey[KEY_SIZE-1 -: KW];
        end else begin : g_key_pad
            assign key_norm = {iKey, {(KW - KEY_SIZE){1'b0}}};
        end
    endgenerate

    assign prev_word = w[cnt - 6'd1];
    assign back_word = w[cnt - NK_CNT];

    // RotWord only on the Nk boundary; the 256-bit mid-step substitutes unrotated.
    assign sub_in = (pos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    // Single shared SubWord unit: four S-boxes.
    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .a (sub_in[8*b +: 8]),
                .s (sub_out[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        new_word = back_word ^ prev_word;
        if (pos == 3'd0) begin
            new_word = back_word ^ sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && pos == 3'd4) begin
            new_word = back_word ^ sub_out;
        end
    end

    // Read port address; out-of-range indices read word 0 and are then masked to zero.
    always_comb begin
        rd_round = iDecrypt ? (NR_IDX - iRoundIdx) : iRoundIdx;
        rd_base  = (iRoundIdx > NR_IDX) ? 6'd0 : {rd_round, 2'b00};
        rd_key   = 128'h0;
        if (iRoundIdx <= NR_IDX) begin
            rd_key = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end
    end

    // Word array is deliberately left unreset.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            if (state == IDLE && iStart) begin
                for (int i = 0; i < NK; i++) begin
                    w[i] <= key_norm[KW-1-32*i -: 32];
                end
            end else if (state == EXPAND) begin
                w[cnt] <= new_word;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            pos       <= 3'd0;
            rcon      <= 8'h01;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oKeyValid <= 1'b0;
            oRoundKey <= 128'h0;
        end else begin
            oDone     <= 1'b0;
            oRoundKey <= rd_key;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        cnt       <= NK_CNT;
                        pos       <= 3'd0;
                        rcon      <= 8'h01;
                        oKeyValid <= 1'b0;
                        oBusy     <= 1'b1;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (pos == 3'd0) rcon <= xtime(rcon);
                    pos <= (pos == LAST_POS) ? 3'd0 : pos + 3'd1;
                    if (cnt == LAST_CNT) begin
                        state     <= IDLE;
                        oBusy     <= 1'b0;
                        oDone     <= 1'b1;
                        oKeyValid <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_iter.sv
// tb/tb_key_schedule_iter.sv - directed self-checking bench for key_schedule_iter
module tb_key_schedule_iter;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R1     = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_R1     = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] B_R10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] KEY_192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] K192_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [255:0] KEY_256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] K256_R0  = 128'h603deb1015ca71be2b73aef0857d7781;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   start_v = 3'b000;
    logic [127:0] key128 = 128'h0;
    logic [191:0] key192 = 192'h0;
    logic [255:0] key256 = 256'h0;
    logic [3:0]   idx = 4'd0;
    logic         dec = 1'b0;
    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [2:0]   kv_v;
    logic [127:0] rk0, rk1, rk2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_schedule_iter #(.KEY_SIZE(128)) dut128 (
        .iClk(clk), .iRst(rst), .iStart(start_v[0]), .iKey(key128),
        .iRoundIdx(idx), .iDecrypt(dec), .oBusy(busy_v[0]), .oDone(done_v[0]),
        .oKeyValid(kv_v[0]), .oRoundKey(rk0));

    key_schedule_iter #(.KEY_SIZE(192)) dut192 (
        .iClk(clk), .iRst(rst), .iStart(start_v[1]), .iKey(key192),
        .iRoundIdx(idx), .iDecrypt(dec), .oBusy(busy_v[1]), .oDone(done_v[1]),
        .oKeyValid(kv_v[1]), .oRoundKey(rk1));

    key_schedule_iter #(.KEY_SIZE(256)) dut256 (
        .iClk(clk), .iRst(rst), .iStart(start_v[2]), .iKey(key256),
        .iRoundIdx(idx), .iDecrypt(dec), .oBusy(busy_v[2]), .oDone(done_v[2]),
        .oKeyValid(kv_v[2]), .oRoundKey(rk2));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse start on instance s and count edges until oDone is seen.
    task automatic start_and_wait(input int s, output int lat, output logic busy_seen);
        start_v[s] = 1'b1;
        lat = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            start_v[s] = 1'b0;
            lat++;
            if (lat == 1) busy_seen = busy_v[s];
            if (done_v[s]) break;
        end
    endtask

    task automatic read_rk(input int s, input logic [3:0] r, input logic d, output logic [127:0] v);
        idx = r;
        dec = d;
        @(posedge clk);
        #1;
        v = (s == 0) ? rk0 : (s == 1) ? rk1 : rk2;
    endtask

    initial begin
        int lat;
        int kv_cnt;
        logic b;
        logic [127:0] v;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_done", done_v[0], 1'b0);
        check("rst_kv", kv_v[0], 1'b0);
        check("rst_rk", rk0, 128'h0);
        rst = 1'b0;

        // AES-128 basic
        key128 = KEY_A;
        start_and_wait(0, lat, b);
        check("a128_lat", lat, 41);
        check("a128_busy", b, 1'b1);
        check("a128_kv", kv_v[0], 1'b1);
        check("a128_busy_end", busy_v[0], 1'b0);
        read_rk(0, 4'd1, 1'b0, v);
        check("a128_r1", v, A_R1);
        check("a128_done_fall", done_v[0], 1'b0);
        read_rk(0, 4'd10, 1'b0, v);
        check("a128_r10", v, A_R10);
        read_rk(0, 4'd0, 1'b1, v);
        check("a128_dec0", v, A_R10);
        read_rk(0, 4'd0, 1'b0, v);
        check("a128_r0", v, KEY_A);
        read_rk(0, 4'd15, 1'b0, v);
        check("a128_idx15", v, 128'h0);
        read_rk(0, 4'd15, 1'b1, v);
        check("a128_idx15_dec", v, 128'h0);

        // AES-192
        key192 = KEY_192;
        start_and_wait(1, lat, b);
        check("a192_lat", lat, 47);
        read_rk(1, 4'd12, 1'b0, v);
        check("a192_r12", v, K192_R12);
        read_rk(1, 4'd0, 1'b1, v);
        check("a192_dec0", v, K192_R12);
        read_rk(1, 4'd0, 1'b0, v);
        check("a192_r0", v, K192_R0);
        read_rk(1, 4'd13, 1'b0, v);
        check("a192_idx13", v, 128'h0);

        // AES-256
        key256 = KEY_256;
        start_and_wait(2, lat, b);
        check("a256_lat", lat, 53);
        read_rk(2, 4'd14, 1'b0, v);
        check("a256_r14", v, K256_R14);
        read_rk(2, 4'd0, 1'b0, v);
        check("a256_r0", v, K256_R0);

        // Reset at cycle 20 of an expansion, then a fresh start
        key128 = KEY_B;
        idx = 4'd1;
        dec = 1'b0;
        start_v[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
        end
        check("mid_busy", busy_v[0], 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", busy_v[0], 1'b0);
        check("mrst_done", done_v[0], 1'b0);
        check("mrst_kv", kv_v[0], 1'b0);
        check("mrst_rk", rk0, 128'h0);
        start_and_wait(0, lat, b);
        check("b128_lat", lat, 41);
        read_rk(0, 4'd1, 1'b0, v);
        check("b128_r1", v, B_R1);
        read_rk(0, 4'd10, 1'b0, v);
        check("b128_r10", v, B_R10);

        // Start with a different key mid-expansion is ignored
        key128 = KEY_A;
        start_v[0] = 1'b1;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
            lat++;
            if (lat == 10) begin
                start_v[0] = 1'b1;
                key128 = KEY_B;
            end
            if (done_v[0]) break;
        end
        check("ign_lat", lat, 41);
        read_rk(0, 4'd10, 1'b0, v);
        check("ign_r10", v, A_R10);
        read_rk(0, 4'd1, 1'b0, v);
        check("ign_r1", v, A_R1);

        // Back-to-back: start held high through oDone
        key128 = KEY_A;
        idx = 4'd10;
        dec = 1'b0;
        start_v[0] = 1'b1;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_v[0]) break;
        end
        check("b2b_lat1", lat, 41);
        key128 = KEY_B;
        kv_cnt = kv_v[0] ? 1 : 0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("b2b_old_r10", rk0, A_R10);
        check("b2b_busy", busy_v[0], 1'b1);
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            if (kv_v[0]) kv_cnt++;
            @(posedge clk);
            #1;
            lat++;
            if (done_v[0]) break;
        end
        check("b2b_kv_cycles", kv_cnt, 1);
        check("b2b_lat2", lat, 41);
        read_rk(0, 4'd10, 1'b0, v);
        check("b2b_r10", v, B_R10);
        read_rk(0, 4'd1, 1'b0, v);
        check("b2b_r1", v, B_R1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_iter.md
# key_schedule_iter

Iterative, parametrised AES key-schedule engine. It expands a 128/192/256-bit cipher key into all Nr+1 round keys at one 32-bit word per clock, using a single shared SubWord unit of four SBox instances. It stores the schedule in an internal word array and serves any round key through a registered read port, in forward (encrypt) or reversed (decrypt) round order. It sits between key load and the round datapath, and replaces the fully unrolled combinational expander where area matters.

## Interface
- KEY_SIZE, 128, cipher key width; 128/192/256 legal, any other value behaves as 128.
- Derived: Nk = 4/6/8; Nr = 10/12/14; TOTAL_WORDS = 4*(Nr+1) = 44/52/60.
- iClk  in  1  clock; single clock domain.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  start-expansion request, sampled in IDLE only.
- iKey  in  KEY_SIZE  cipher key, MSB-first (word 0 = iKey[KEY_SIZE-1 -: 32]); sampled only on the accepted iStart edge.
- iRoundIdx  in  4  round-key index 0..Nr for the read port.
- iDecrypt  in  1  0: read round iRoundIdx; 1: read round Nr-iRoundIdx.
- oBusy  out  1  expansion in progress.
- oDone  out  1  one-cycle pulse when the schedule is complete.
- oKeyValid  out  1  level; the full schedule in the array is valid.
- oRoundKey  out  128  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation
- FSM states: IDLE and EXPAND.
- IDLE + iStart:
  - write w[0..Nk-1] from iKey;
  - set cnt = Nk and rcon = 8'h01;
  - clear oKeyValid, set oBusy, go to EXPAND.
- EXPAND, one edge per word: write w[cnt] = w[cnt-Nk] ^ t, where t is:
  - cnt%Nk==0: SubWord(RotWord(w[cnt-1])) ^ {rcon,24'h0}; after use, rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  - KEY_SIZE==256 && cnt%Nk==4: SubWord(w[cnt-1]);
  - otherwise: w[cnt-1].
  - RotWord(a,b,c,d) = (b,c,d,a).
- Last word: on the edge writing w[TOTAL_WORDS-1], go to IDLE, clear oBusy, and set oDone and oKeyValid.
- cnt is 6 bits; it never wraps, because it stops at TOTAL_WORDS-1.
- Read port, every edge in any state:
  - r = iDecrypt ? Nr-iRoundIdx : iRoundIdx;
  - oRoundKey <= (iRoundIdx > Nr) ? 128'h0 : {w[4r..4r+3]}.
  - Reading during EXPAND returns the partial array contents; consumers must gate on oKeyValid.
- iStart in EXPAND is ignored; iKey changes during EXPAND are ignored.
- iStart in IDLE with oKeyValid=1 restarts: oKeyValid drops on that edge and the old schedule is overwritten.
- iRst, including mid-expansion, forces:
  - state IDLE, cnt 0, rcon 8'h01;
  - oBusy, oDone, oKeyValid 0;
  - oRoundKey 128'h0.
  - The word array is not reset. iRst dominates a simultaneous iStart.

## Timing
- Start edge = E0. Words are written on edges E1..E(TOTAL_WORDS-Nk).
- Expansion length is 40/46/52 edges for 128/192/256.
- oBusy is high from after E0 through the cycle that ends at the last-word edge.
- oDone and oKeyValid rise after the last-word edge; oDone falls one cycle later.
- Start-to-oDone latency: 41/47/53 cycles.
- A new iStart is accepted in the same cycle oDone is high, because the state is IDLE.
- Read latency is 1 cycle: iRoundIdx/iDecrypt at edge N give oRoundKey after edge N.
- Critical path: w[cnt-1] mux -> 4x SBox -> XOR -> array write; one SubWord per cycle.

## Test plan
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, iStart pulse:
  - oDone exactly 41 cycles after start;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - iDecrypt=1 with idx 0 returns the round-10 value.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - oDone after 47 cycles;
  - round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - oDone after 53 cycles;
  - round 14 = fe4890d1e6188d0b046df344706c631e;
  - round 0 = first 128 key bits.
- Robustness:
  - iStart with a different key mid-expansion -> ignored, same results and latency;
  - iRoundIdx=15 -> oRoundKey 0.
- iRst asserted at cycle 20 of an expansion:
  - next cycle oBusy, oDone, oKeyValid all 0 and oRoundKey 0;
  - a subsequent fresh start yields correct keys.
- Back-to-back: iStart held high through oDone restarts immediately:
  - oKeyValid is high for exactly one cycle;
  - the second schedule matches the new iKey.
